// File: rtl/ir_key_dec.sv
// NEC IR key decoder: validates frames, filters by address and
// turns frames and repeat codes into press / auto-repeat key events.
module ir_key_dec #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd6_000_000,
    parameter logic [3:0]  RPT_START   = 4'd3,
    parameter logic [3:0]  RPT_DIV     = 4'd2,
    parameter logic        ADDR_EN     = 1'b0,
    parameter logic [7:0]  ADDR        = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_rpt_vld,
    output logic [7:0]  o_key,
    output logic [7:0]  o_addr,
    output logic        o_key_vld,
    output logic        o_key_rpt,
    output logic        o_held,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] timer;
    logic [31:0] timer_nxt;
    logic [3:0]  rpt_cnt;
    logic [3:0]  rpt_cnt_nxt;
    logic [3:0]  rpt_inc;
    logic        frm_ok;
    logic        frm_bad;
    logic        frm_acc;
    logic        rpt_in;
    logic        rpt_hit;
    logic        timeout;
    logic        key_vld_nxt;
    logic        key_rpt_nxt;

    assign frm_ok  = (i_frame[23:16] == ~i_frame[31:24]) &&
                     (i_frame[7:0] == ~i_frame[15:8]);
    assign frm_bad = i_frame_vld && !frm_ok;
    assign frm_acc = i_frame_vld && frm_ok &&
                     (!ADDR_EN || (i_frame[31:24] == ADDR));

    // A frame in the same cycle always masks the repeat strobe.
    assign rpt_in  = i_rpt_vld && !i_frame_vld && (state != IDLE);
    assign rpt_inc = rpt_cnt + 4'd1;
    assign rpt_hit = rpt_in &&
                     (rpt_inc == ((state == PRESS) ? RPT_START : RPT_DIV));
    assign timeout = (state != IDLE) && !i_frame_vld && !rpt_in &&
                     (timer == TIMEOUT_CYC - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (frm_acc) state_nxt = PRESS;
            end
            PRESS: begin
                if (frm_acc)      state_nxt = PRESS;
                else if (rpt_hit) state_nxt = HOLD;
                else if (timeout) state_nxt = IDLE;
            end
            HOLD: begin
                if (frm_acc)      state_nxt = PRESS;
                else if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Invalid or filtered frames freeze the timer for that cycle.
    always_comb begin
        key_vld_nxt = frm_acc || rpt_hit;
        key_rpt_nxt = o_key_rpt;
        if (frm_acc)      key_rpt_nxt = 1'b0;
        else if (rpt_hit) key_rpt_nxt = 1'b1;

        timer_nxt = timer + 32'd1;
        if (frm_acc || rpt_in || (state_nxt == IDLE)) timer_nxt = '0;
        else if (i_frame_vld)                          timer_nxt = timer;

        rpt_cnt_nxt = rpt_cnt;
        if (frm_acc || rpt_hit || (state_nxt == IDLE)) rpt_cnt_nxt = '0;
        else if (rpt_in)                                 rpt_cnt_nxt = rpt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            rpt_cnt   <= '0;
            o_key     <= '0;
            o_addr    <= '0;
            o_key_vld <= 1'b0;
            o_key_rpt <= 1'b0;
            o_held    <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            timer     <= timer_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            o_key_vld <= key_vld_nxt;
            o_key_rpt <= key_rpt_nxt;
            o_held    <= (state_nxt != IDLE);
            o_err     <= frm_bad;
            if (frm_acc) begin
                o_key  <= i_frame[15:8];
                o_addr <= i_frame[31:24];
            end
            if (frm_bad && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule
